// File: rtl/spike_gen_array.sv
// Bank of 2**NGENS_LOG programmable periodic/one-shot spike generators.
// Each unit_pulse triggers one serial scan; each firing generator emits one {tag,ct} token.
module spike_gen_array #(
    parameter int NGENS_LOG = 8,
    parameter int NPERIOD   = 16,
    parameter int NTAG      = 11,
    parameter int NCT       = 10,
    parameter int NOVR      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   unit_pulse,
    input  logic [NGENS_LOG-1:0]   gens_used,
    input  logic [2**NGENS_LOG-1:0] gens_en,
    input  logic [NGENS_LOG-1:0]   prog_gen_idx,
    input  logic [NPERIOD-1:0]     prog_period,
    input  logic [NPERIOD-1:0]     prog_ticks,
    input  logic [NTAG-1:0]        prog_tag,
    input  logic [NCT-1:0]         prog_ct,
    input  logic                   prog_oneshot,
    input  logic                   prog_v,
    output logic                   prog_a,
    output logic [NTAG-1:0]        out_tag,
    output logic [NCT-1:0]         out_ct,
    output logic                   out_v,
    input  logic                   out_a,
    output logic                   busy,
    output logic [NOVR-1:0]        overrun_ct
);

    localparam int NG = 2**NGENS_LOG;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]           state;
    logic [NGENS_LOG-1:0] idx;
    logic                 pending;

    logic [NPERIOD-1:0] period_mem [NG];
    logic [NPERIOD-1:0] ticks_mem  [NG];
    logic [NTAG-1:0]    tag_mem    [NG];
    logic [NCT-1:0]     ct_mem     [NG];
    logic [NG-1:0]      oneshot;
    logic [NG-1:0]      armed;

    logic [NPERIOD-1:0] cur_period;
    logic [NPERIOD-1:0] cur_ticks;
    logic               cur_active;
    logic               cur_fire;
    logic               cur_last;
    logic               prog_xfer;

    always_comb begin
        cur_period = period_mem[idx];
        cur_ticks  = ticks_mem[idx];
        cur_active = gens_en[idx] & armed[idx] & (cur_period != '0);
        cur_fire   = (state == SCAN) & cur_active & (cur_ticks == '0);
        cur_last   = (idx == gens_used);
    end

    // A pulse in the same cycle as a program request wins; the request is retried after the scan.
    assign prog_a    = (state == IDLE) & ~unit_pulse & ~pending;
    assign prog_xfer = prog_v & prog_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NG; i++) begin
                period_mem[NGENS_LOG'(i)] <= '0;
                ticks_mem[NGENS_LOG'(i)]  <= '0;
                tag_mem[NGENS_LOG'(i)]    <= '0;
                ct_mem[NGENS_LOG'(i)]     <= '0;
            end
            oneshot <= '0;
            armed   <= '0;
        end else if (prog_xfer) begin
            period_mem[prog_gen_idx] <= prog_period;
            ticks_mem[prog_gen_idx]  <= prog_ticks;
            tag_mem[prog_gen_idx]    <= prog_tag;
            ct_mem[prog_gen_idx]     <= prog_ct;
            oneshot[prog_gen_idx]    <= prog_oneshot;
            armed[prog_gen_idx]      <= 1'b1;
        end else if ((state == SCAN) && cur_active) begin
            if (cur_ticks != '0) begin
                ticks_mem[idx] <= cur_ticks - NPERIOD'(1);
            end else begin
                ticks_mem[idx] <= cur_period - NPERIOD'(1);
                if (oneshot[idx]) begin
                    armed[idx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            out_v      <= 1'b0;
            out_tag    <= '0;
            out_ct     <= '0;
            overrun_ct <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (unit_pulse || pending) begin
                        state   <= SCAN;
                        idx     <= '0;
                        busy    <= 1'b1;
                        // a fresh pulse arriving while a pending scan launches stays queued
                        pending <= pending & unit_pulse;
                    end
                end
                SCAN: begin
                    if (cur_fire) begin
                        out_tag <= tag_mem[idx];
                        out_ct  <= ct_mem[idx];
                        out_v   <= 1'b1;
                        state   <= EMIT;
                    end else if (cur_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + NGENS_LOG'(1);
                    end
                end
                EMIT: begin
                    if (out_a) begin
                        out_v <= 1'b0;
                        if (cur_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= idx + NGENS_LOG'(1);
                            state <= SCAN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    out_v <= 1'b0;
                end
            endcase

            if ((state != IDLE) && unit_pulse) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else if (overrun_ct != '1) begin
                    overrun_ct <= overrun_ct + NOVR'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_gen_array.sv
// Directed bench for spike_gen_array: vector table of single-generator schedules
// plus hand-written stall, overrun, program/pulse collision and async reset sequences.
module tb_spike_gen_array;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          unit_pulse;
    logic [7:0]    gens_used;
    logic [255:0]  gens_en;
    logic [7:0]    prog_gen_idx;
    logic [15:0]   prog_period;
    logic [15:0]   prog_ticks;
    logic [10:0]   prog_tag;
    logic [9:0]    prog_ct;
    logic          prog_oneshot;
    logic          prog_v;
    logic          prog_a;
    logic [10:0]   out_tag;
    logic [9:0]    out_ct;
    logic          out_v;
    logic          out_a;
    logic          busy;
    logic [7:0]    overrun_ct;

    int checks = 0;
    int errors = 0;

    spike_gen_array #(
        .NGENS_LOG(8),
        .NPERIOD(16),
        .NTAG(11),
        .NCT(10),
        .NOVR(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .unit_pulse(unit_pulse),
        .gens_used(gens_used),
        .gens_en(gens_en),
        .prog_gen_idx(prog_gen_idx),
        .prog_period(prog_period),
        .prog_ticks(prog_ticks),
        .prog_tag(prog_tag),
        .prog_ct(prog_ct),
        .prog_oneshot(prog_oneshot),
        .prog_v(prog_v),
        .prog_a(prog_a),
        .out_tag(out_tag),
        .out_ct(out_ct),
        .out_v(out_v),
        .out_a(out_a),
        .busy(busy),
        .overrun_ct(overrun_ct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  gen;
        logic [15:0] period;
        logic [15:0] ticks;
        logic [10:0] tag;
        logic [9:0]  ct;
        logic        oneshot;
        int          npulses;
        logic [15:0] fire_mask;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] gen, input logic [15:0] period, input logic [15:0] ticks,
                        input logic [10:0] tag, input logic [9:0] ct, input logic os);
        int cyc;
        prog_gen_idx = gen;
        prog_period  = period;
        prog_ticks   = ticks;
        prog_tag     = tag;
        prog_ct      = ct;
        prog_oneshot = os;
        prog_v       = 1'b1;
        cyc = 0;
        while (!prog_a && cyc < 2000) begin
            step();
            cyc++;
        end
        check("prog_a", prog_a, 1);
        step();
        prog_v = 1'b0;
    endtask

    // One pulse, out_a assumed high; count tokens and keep the last one seen.
    task automatic pulse_collect(output int ntok, output logic [10:0] tg, output logic [9:0] c);
        int cyc;
        ntok = 0;
        tg = '0;
        c = '0;
        unit_pulse = 1'b1;
        step();
        unit_pulse = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            if (out_v) begin
                ntok++;
                tg = out_tag;
                c = out_ct;
            end
            step();
            cyc++;
        end
        check("scan_done", busy, 0);
    endtask

    task automatic wait_out_v();
        int cyc;
        cyc = 0;
        while (!out_v && cyc < 100) begin
            step();
            cyc++;
        end
        check("out_v_rise", out_v, 1);
    endtask

    initial begin
        int ntok;
        int cyc;
        logic [10:0] tg;
        logic [9:0]  c;
        logic [10:0] seen_tags [$];

        vecs[0] = '{gen: 8'd0,   period: 16'd3, ticks: 16'd0, tag: 11'd5,     ct: 10'd1,     oneshot: 1'b0, npulses: 7, fire_mask: 16'h0049};
        vecs[1] = '{gen: 8'd2,   period: 16'd2, ticks: 16'd1, tag: 11'h7FF,   ct: 10'h3FF,   oneshot: 1'b1, npulses: 5, fire_mask: 16'h0002};
        vecs[2] = '{gen: 8'd5,   period: 16'd1, ticks: 16'd0, tag: 11'h123,   ct: 10'h045,   oneshot: 1'b0, npulses: 3, fire_mask: 16'h0007};
        vecs[3] = '{gen: 8'd255, period: 16'd0, ticks: 16'd0, tag: 11'h0AA,   ct: 10'h055,   oneshot: 1'b0, npulses: 3, fire_mask: 16'h0000};
        vecs[4] = '{gen: 8'd7,   period: 16'd4, ticks: 16'd2, tag: 11'h300,   ct: 10'h200,   oneshot: 1'b0, npulses: 7, fire_mask: 16'h0044};

        reset_n = 1'b0;
        unit_pulse = 1'b0;
        gens_used = '0;
        gens_en = '0;
        prog_gen_idx = '0;
        prog_period = '0;
        prog_ticks = '0;
        prog_tag = '0;
        prog_ct = '0;
        prog_oneshot = 1'b0;
        prog_v = 1'b0;
        out_a = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        check("rst_out_v", out_v, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_ct, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_ct", out_ct, 0);
        check("rst_prog_a", prog_a, 1);

        for (int vi = 0; vi < 5; vi++) begin
            prog(vecs[vi].gen, vecs[vi].period, vecs[vi].ticks, vecs[vi].tag, vecs[vi].ct, vecs[vi].oneshot);
            gens_en = '0;
            gens_en[vecs[vi].gen] = 1'b1;
            gens_used = vecs[vi].gen;
            for (int p = 0; p < vecs[vi].npulses; p++) begin
                pulse_collect(ntok, tg, c);
                check($sformatf("v%0d_p%0d_tokens", vi, p + 1), 64'(ntok), 64'(vecs[vi].fire_mask[4'(p)]));
                if (vecs[vi].fire_mask[4'(p)]) begin
                    check($sformatf("v%0d_p%0d_tag", vi, p + 1), tg, vecs[vi].tag);
                    check($sformatf("v%0d_p%0d_ct", vi, p + 1), c, vecs[vi].ct);
                end
            end
        end

        // Stalled output: gens 0..3 all fire every unit.
        for (int i = 0; i < 4; i++) begin
            prog(8'(i), 16'd1, 16'd0, 11'(16 + i), 10'(i), 1'b0);
        end
        gens_en = 256'hF;
        gens_used = 8'd3;
        out_a = 1'b0;
        unit_pulse = 1'b1;
        step();
        unit_pulse = 1'b0;
        wait_out_v();
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("stall_out_v_%0d", k), out_v, 1);
            check($sformatf("stall_out_tag_%0d", k), out_tag, 11'h10);
            check($sformatf("stall_busy_%0d", k), busy, 1);
        end
        out_a = 1'b1;
        seen_tags.delete();
        cyc = 0;
        while (busy && cyc < 100) begin
            if (out_v) seen_tags.push_back(out_tag);
            step();
            cyc++;
        end
        check("stall_scan_done", busy, 0);
        check("stall_token_count", 64'(seen_tags.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen_tags.size()) check($sformatf("stall_order_%0d", i), seen_tags[i], 11'(16 + i));
        end

        // Pulses while stalled: first one pends, the rest count as overruns.
        check("ovr_start", overrun_ct, 0);
        out_a = 1'b0;
        unit_pulse = 1'b1;
        step();
        unit_pulse = 1'b0;
        wait_out_v();
        for (int k = 0; k < 100; k++) begin
            unit_pulse = 1'b1;
            step();
            unit_pulse = 1'b0;
            step();
        end
        check("ovr_99", overrun_ct, 99);
        check("ovr_busy", busy, 1);
        for (int k = 0; k < 200; k++) begin
            unit_pulse = 1'b1;
            step();
            unit_pulse = 1'b0;
            step();
        end
        check("ovr_saturate", overrun_ct, 255);
        out_a = 1'b1;
        ntok = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_v) ntok++;
            step();
        end
        check("ovr_tokens_two_scans", 64'(ntok), 8);
        check("ovr_idle_after", busy, 0);
        check("ovr_hold", overrun_ct, 255);

        // Asynchronous reset in the middle of EMIT.
        out_a = 1'b0;
        unit_pulse = 1'b1;
        step();
        unit_pulse = 1'b0;
        wait_out_v();
        reset_n = 1'b0;
        #2;
        check("arst_out_v", out_v, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun_ct, 0);
        repeat (2) step();
        reset_n = 1'b1;
        out_a = 1'b1;
        step();
        pulse_collect(ntok, tg, c);
        check("arst_no_token", 64'(ntok), 0);

        // Program request colliding with a unit pulse in IDLE.
        gens_en = 256'h1;
        gens_used = 8'd0;
        prog_gen_idx = 8'd0;
        prog_period = 16'd1;
        prog_ticks = 16'd0;
        prog_tag = 11'h055;
        prog_ct = 10'h02A;
        prog_oneshot = 1'b0;
        prog_v = 1'b1;
        unit_pulse = 1'b1;
        #1;
        check("coll_prog_a_pulse", prog_a, 0);
        step();
        unit_pulse = 1'b0;
        check("coll_busy", busy, 1);
        check("coll_prog_a_busy", prog_a, 0);
        ntok = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            if (out_v) ntok++;
            step();
            cyc++;
        end
        check("coll_scan_cycles", 64'(cyc), 1);
        check("coll_scan_no_token", 64'(ntok), 0);
        check("coll_prog_a_idle", prog_a, 1);
        step();
        prog_v = 1'b0;
        pulse_collect(ntok, tg, c);
        check("coll_after_tokens", 64'(ntok), 1);
        check("coll_after_tag", tg, 11'h055);
        check("coll_after_ct", c, 10'h02A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
